// File: rtl/mem_stage_access_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_pkg : shared encodings for the memory-stage access unit
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   // MemCtrl carries funct3 of the load/store instruction
   localparam logic [2:0] MC_B  = 3'b000;
   localparam logic [2:0] MC_H  = 3'b001;
   localparam logic [2:0] MC_W  = 3'b010;
   localparam logic [2:0] MC_BU = 3'b100;
   localparam logic [2:0] MC_HU = 3'b101;

   localparam logic [1:0] RS_ALU = 2'b00;
   localparam logic [1:0] RS_MEM = 2'b01;
   localparam logic [1:0] RS_PC4 = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_access_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_access_if : data-cache request/response channel
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_stage_access_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  dc_req_valid;
   logic                  dc_req_ready;
   logic                  dc_req_we;
   logic [DATA_WIDTH-1:0] dc_req_addr;
   logic [DATA_WIDTH-1:0] dc_req_wdata;
   logic [3:0]            dc_req_be;
   logic                  dc_resp_valid;
   logic [DATA_WIDTH-1:0] dc_resp_rdata;

   modport master (
      output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be,
      input  dc_req_ready, dc_resp_valid, dc_resp_rdata
   );

   modport slave (
      input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be,
      output dc_req_ready, dc_resp_valid, dc_resp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_access_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align : store lane steering, load extract/extension, access fault check
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_CTRL_WIDTH = 3
) (
   input  logic [1:0]                addr_lo,
   input  logic [MEM_CTRL_WIDTH-1:0] mem_ctrl,
   input  logic                      is_store,
   input  logic [DATA_WIDTH-1:0]     store_data,
   input  logic [DATA_WIDTH-1:0]     load_word,
   output logic [DATA_WIDTH-1:0]     lane_wdata,
   output logic [3:0]                lane_be,
   output logic [DATA_WIDTH-1:0]     load_data,
   output logic                      fault
);

   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      shifted    = load_word >> {addr_lo, 3'b000};
      lane_wdata = store_data;
      lane_be    = 4'b1111;
      load_data  = load_word;
      fault      = 1'b0;
      case (mem_ctrl)
         MC_B: begin
            lane_wdata = {(DATA_WIDTH/8){store_data[7:0]}};
            lane_be    = 4'b0001 << addr_lo;
            load_data  = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
         end
         MC_H: begin
            lane_wdata = {(DATA_WIDTH/16){store_data[15:0]}};
            lane_be    = 4'b0011 << addr_lo;
            load_data  = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            fault      = addr_lo[0];
         end
         MC_W: begin
            fault = (addr_lo != 2'b00);
         end
         // Unsigned forms exist only for loads
         MC_BU: begin
            lane_be   = 4'b0001 << addr_lo;
            load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            fault     = is_store;
         end
         MC_HU: begin
            lane_be   = 4'b0011 << addr_lo;
            load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            fault     = is_store | addr_lo[0];
         end
         default: begin
            fault = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_access : load/store sequencing against the data cache, pipeline
//                    stall generation and registered writeback bundle
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage_access
   import mem_stage_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int READ_DATA_WIDTH = 5,
   parameter int SRC_WIDTH       = 2,
   parameter int MEM_CTRL_WIDTH  = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid_m,
   input  logic [DATA_WIDTH-1:0]      PCPlus4_m,
   input  logic [DATA_WIDTH-1:0]      ALUResult_m,
   input  logic [DATA_WIDTH-1:0]      WriteData_m,
   input  logic [READ_DATA_WIDTH-1:0] Rd_m,
   input  logic                       RegWrite_m,
   input  logic [SRC_WIDTH-1:0]       ResultSrc_m,
   input  logic                       MemWrite_m,
   input  logic [MEM_CTRL_WIDTH-1:0]  MemCtrl_m,
   output logic                       mem_stall,
   mem_stage_access_if.master         dc,
   output logic                       valid_w,
   output logic [DATA_WIDTH-1:0]      PCPlus4_w,
   output logic [DATA_WIDTH-1:0]      ALUResult_w,
   output logic [DATA_WIDTH-1:0]      ReadData_w,
   output logic [READ_DATA_WIDTH-1:0] Rd_w,
   output logic                       RegWrite_w,
   output logic [SRC_WIDTH-1:0]       ResultSrc_w,
   output logic                       fault_w
);

   state_t                     state_q, state_d;
   logic                       valid_w_q, valid_w_d;
   logic [DATA_WIDTH-1:0]      pc4_q, pc4_d;
   logic [DATA_WIDTH-1:0]      alu_q, alu_d;
   logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
   logic [READ_DATA_WIDTH-1:0] rd_q, rd_d;
   logic                       regwrite_q, regwrite_d;
   logic [SRC_WIDTH-1:0]       src_q, src_d;
   logic                       fault_q, fault_d;

   logic                  is_load, is_store, mem_op, align_fault, op_fault, need_req;
   logic                  complete, capture_load;
   logic [DATA_WIDTH-1:0] lane_wdata, load_data;
   logic [3:0]            lane_be;

   assign is_load  = valid_m && (ResultSrc_m == SRC_WIDTH'(RS_MEM));
   assign is_store = valid_m && MemWrite_m;
   assign mem_op   = is_load || is_store;
   assign op_fault = mem_op && align_fault;
   assign need_req = mem_op && !align_fault;

   mem_align #(
      .DATA_WIDTH     (DATA_WIDTH),
      .MEM_CTRL_WIDTH (MEM_CTRL_WIDTH)
   ) u_align (
      .addr_lo    (ALUResult_m[1:0]),
      .mem_ctrl   (MemCtrl_m),
      .is_store   (is_store),
      .store_data (WriteData_m),
      .load_word  (dc.dc_resp_rdata),
      .lane_wdata (lane_wdata),
      .lane_be    (lane_be),
      .load_data  (load_data),
      .fault      (align_fault)
   );

   always_comb begin
      state_d      = state_q;
      complete     = 1'b0;
      capture_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!need_req) begin
               complete = 1'b1;
            end else if (dc.dc_req_ready) begin
               if (is_store) complete = 1'b1;
               else          state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dc.dc_resp_valid) begin
               complete     = 1'b1;
               capture_load = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mem_stall       = !complete;
   assign dc.dc_req_valid = (state_q == ST_IDLE) && need_req;
   assign dc.dc_req_we    = is_store;
   assign dc.dc_req_addr  = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};
   assign dc.dc_req_wdata = lane_wdata;
   assign dc.dc_req_be    = lane_be;

   // Stall cycles emit a bubble; payload fields keep their last value
   always_comb begin
      valid_w_d  = complete && valid_m;
      pc4_d      = pc4_q;
      alu_d      = alu_q;
      rdata_d    = rdata_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      src_d      = src_q;
      fault_d    = fault_q;
      if (complete) begin
         pc4_d      = PCPlus4_m;
         alu_d      = ALUResult_m;
         rdata_d    = capture_load ? load_data : '0;
         rd_d       = Rd_m;
         regwrite_d = RegWrite_m && !op_fault;
         src_d      = ResultSrc_m;
         fault_d    = op_fault;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         valid_w_q  <= 1'b0;
         pc4_q      <= '0;
         alu_q      <= '0;
         rdata_q    <= '0;
         rd_q       <= '0;
         regwrite_q <= 1'b0;
         src_q      <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_w_q  <= valid_w_d;
         pc4_q      <= pc4_d;
         alu_q      <= alu_d;
         rdata_q    <= rdata_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         src_q      <= src_d;
         fault_q    <= fault_d;
      end
   end

   assign valid_w     = valid_w_q;
   assign PCPlus4_w   = pc4_q;
   assign ALUResult_w = alu_q;
   assign ReadData_w  = rdata_q;
   assign Rd_w        = rd_q;
   assign RegWrite_w  = regwrite_q;
   assign ResultSrc_w = src_q;
   assign fault_w     = fault_q;

endmodule
`default_nettype wire
